// File: rtl/operand_negator.sv
// Pass / NOT / negate / abs of a WIDTH-bit operand. The +1 carry ripples CHUNK bits per cycle.
// The result is valid WIDTH/CHUNK cycles after accept and is held until out_ready; accepts only in IDLE.
module operand_negator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op, res, res_nxt;
  logic [KW-1:0]    k;
  logic             inv, carry, neg;
  logic             neg_in, accept, last;
  logic [CHUNK:0]   sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid && !reset) state_nxt = CALC;
      end
      CALC: if (k == KLAST) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign last   = (state == CALC) && (k == KLAST);
  assign neg_in = (mode == 2'b10) | ((mode == 2'b11) & in_data[WIDTH-1]);

  // One chunk of the conditional invert-and-increment; the carry links chunks across cycles.
  always_comb begin
    sum     = {1'b0, op[int'(k)*CHUNK +: CHUNK] ^ {CHUNK{inv}}} + (CHUNK+1)'(carry);
    res_nxt = res;
    res_nxt[int'(k)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op       <= '0;
      res      <= '0;
      k        <= '0;
      inv      <= 1'b0;
      carry    <= 1'b0;
      neg      <= 1'b0;
      out_data <= '0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      op    <= in_data;
      neg   <= neg_in;
      inv   <= neg_in | (mode == 2'b01);
      carry <= neg_in;
      k     <= '0;
    end else if (state == CALC) begin
      res   <= res_nxt;
      carry <= sum[CHUNK];
      k     <= k + KW'(1);
      // Outputs change only on entry to DONE so they hold steady through IDLE/CALC.
      if (last) begin
        out_data <= res_nxt;
        out_neg  <= neg;
        out_ovf  <= neg & (op == MOST_NEG);
      end
    end
  end

endmodule

// File: tb/tb_operand_negator.sv
// Bench for operand_negator: 8-bit-chunk instance for most scenarios, full-width-chunk instance for latency 1.
module tb_operand_negator;

  typedef struct packed {
    logic [31:0] data;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  mode = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_neg, out_ovf;

  logic        w_in_valid = 1'b0, w_in_ready;
  logic [31:0] w_in_data = '0;
  logic [1:0]  w_mode = '0;
  logic        w_out_valid, w_out_ready = 1'b1;
  logic [31:0] w_out_data;
  logic        w_out_neg, w_out_ovf;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  operand_negator #(.WIDTH(32), .CHUNK(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_neg(out_neg), .out_ovf(out_ovf)
  );

  operand_negator #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .mode(w_mode), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_neg(w_out_neg), .out_ovf(w_out_ovf)
  );

  function automatic exp_t model(input logic [1:0] m, input logic [31:0] d);
    exp_t e;
    logic n;
    n = (m == 2'b10) || (m == 2'b11 && d[31]);
    e.neg  = n;
    e.data = n ? (32'd0 - d) : (m == 2'b01) ? ~d : d;
    e.ovf  = n && (d == 32'h8000_0000);
    return e;
  endfunction

  // Present one operand, push its expectation, then scramble inputs to prove they were latched.
  task automatic send_op(input logic [1:0] m, input logic [31:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (ok) begin
      mode = m;
      in_data = d;
      in_valid = 1'b1;
      sb.push_back(model(m, d));
      @(posedge clock); #1;
      in_valid = 1'b0;
      mode = 2'($urandom);
      in_data = $urandom;
    end
  endtask

  task automatic wait_out(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
    total++; if ({out_data, out_neg, out_ovf} !== 34'd0)
      $display("FAIL rst_outputs got %h/%b/%b want 0/0/0", out_data, out_neg, out_ovf); else passed++;
    total++; if (w_in_ready !== 1'b0 || w_out_valid !== 1'b0)
      $display("FAIL rst_w32 got rdy=%b vld=%b want 0/0", w_in_ready, w_out_valid); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_negate_latency;
    bit ok, to;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    send_op(2'b10, 32'h0000_0005, ok);
    total++; if (!ok) $display("FAIL neg_accept got not_ready want ready"); else passed++;
    wait_out(lat, to);
    e = sb.pop_front();
    total++; if (to || lat != 4) $display("FAIL neg_latency got %0d (timeout=%b) want 4", lat, to); else passed++;
    total++; if (out_data !== 32'hFFFF_FFFB || out_data !== e.data)
      $display("FAIL neg_data got %h want %h", out_data, e.data); else passed++;
    total++; if (out_neg !== 1'b1 || out_ovf !== 1'b0)
      $display("FAIL neg_flags got neg=%b ovf=%b want 1/0", out_neg, out_ovf); else passed++;
    @(posedge clock); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL neg_return_idle got vld=%b rdy=%b want 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_modes;
    logic [1:0]  tm[8] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] td[8] = '{32'h8000_0000, 32'hFFFF_FFF9, 32'h0F0F_00FF, 32'h1234_5678,
                           32'h0000_0000, 32'h0000_0100, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    bit ok, to;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  m;
      logic [31:0] d;
      m = (i < 8) ? tm[i] : 2'($urandom);
      d = (i < 8) ? td[i] : $urandom;
      send_op(m, d, ok);
      if (!ok) begin
        total++; $display("FAIL modes_accept[%0d] got not_ready want ready", i);
        continue;
      end
      wait_out(lat, to);
      e = sb.pop_front();
      total++; if (to || lat != 4) $display("FAIL modes_latency[%0d] got %0d want 4", i, lat); else passed++;
      total++; if (out_data !== e.data || out_neg !== e.neg || out_ovf !== e.ovf)
        $display("FAIL modes_result[%0d] mode=%b in=%h got %h/%b/%b want %h/%b/%b",
                 i, m, d, out_data, out_neg, out_ovf, e.data, e.neg, e.ovf);
      else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok, to;
    int lat;
    exp_t e;
    out_ready = 1'b0;
    send_op(2'b10, 32'h0000_1234, ok);
    wait_out(lat, to);
    e = sb.pop_front();
    total++; if (!ok || to) $display("FAIL bp_reach_done got ok=%b timeout=%b want 1/0", ok, to); else passed++;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        in_valid = 1'b1;
        mode = 2'b00;
        in_data = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b0;
      end
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data || out_neg !== e.neg)
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b data=%h want 1/0/%h", c, out_valid, in_ready, out_data, e.data);
      else passed++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready); else passed++;
    send_op(2'b01, 32'hA5A5_0000, ok);
    wait_out(lat, to);
    e = sb.pop_front();
    total++; if (!ok || to || lat != 4 || out_data !== e.data)
      $display("FAIL bp_next_op got %h lat=%0d want %h lat=4", out_data, lat, e.data); else passed++;
    @(posedge clock); #1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) break;
      @(posedge clock); #1;
    end
    total++; if (out_valid !== 1'b0) $display("FAIL bp_no_ghost got vld=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid_calc;
    bit ok, to;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    send_op(2'b10, 32'h0000_0077, ok);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    void'(sb.pop_front());
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'd0)
      $display("FAIL midrst_state got vld=%b rdy=%b data=%h want 0/0/0", out_valid, in_ready, out_data);
    else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL midrst_release got %b want 1", in_ready); else passed++;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) break;
      @(posedge clock); #1;
    end
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_abandon got vld=%b want 0", out_valid); else passed++;
    send_op(2'b10, 32'h0000_0001, ok);
    wait_out(lat, to);
    e = sb.pop_front();
    total++; if (!ok || to || lat != 4 || out_data !== 32'hFFFF_FFFF || out_data !== e.data || out_ovf !== 1'b0)
      $display("FAIL midrst_next got %h lat=%0d want ffffffff lat=4", out_data, lat); else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_chunk32;
    exp_t e;
    int lat;
    bit to;
    w_out_ready = 1'b1;
    total++; if (w_in_ready !== 1'b1) $display("FAIL w32_ready got %b want 1", w_in_ready); else passed++;
    w_mode = 2'b10;
    w_in_data = 32'h0000_0005;
    w_in_valid = 1'b1;
    e = model(2'b10, 32'h0000_0005);
    @(posedge clock); #1;
    w_in_valid = 1'b0;
    w_in_data = '0;
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (w_out_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clock); #1;
      lat++;
    end
    total++; if (to || lat != 1) $display("FAIL w32_latency got %0d want 1", lat); else passed++;
    total++; if (w_out_data !== e.data || w_out_neg !== 1'b1 || w_out_ovf !== 1'b0)
      $display("FAIL w32_result got %h/%b/%b want %h/1/0", w_out_data, w_out_neg, w_out_ovf, e.data); else passed++;
    @(posedge clock); #1;
    total++; if (w_out_valid !== 1'b0) $display("FAIL w32_idle got %b want 0", w_out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_negate_latency();
    test_modes();
    test_backpressure();
    test_reset_mid_calc();
    test_chunk32();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
